pts_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one parallel-to-serial shifter among NREQ requesters. It selects a requester, captures its word, and drives the shifter's load/shift control (start low = load, start high = shift). It waits for the shifter's done, then returns a one-cycle acknowledge to the requester. A watchdog aborts transfers whose done never arrives.

---
 rtl/pts_rr_arbiter_if.sv | 27 ++
 rtl/pts_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_pts_rr_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pts_rr_arbiter_if.sv
// Bundle between the round-robin arbiter, its requesters and the shared shifter.
// The arbiter connects through the slave modport. The requester/shifter side connects through master.
interface pts_rr_arbiter_if #(
    parameter int WORD = 8,
    parameter int NREQ = 4
) ();
    logic [NREQ-1:0]      req;
    logic [NREQ*WORD-1:0] data_in;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      ack;
    logic                 err;
    logic [2:0]           err_id;
    logic [WORD-1:0]      ser_data;
    logic                 ser_start;
    logic                 ser_done;
    logic                 busy;

    modport slave (
        input  req, data_in, ser_done,
        output grant, ack, err, err_id, ser_data, ser_start, busy
    );

    modport master (
        output req, data_in, ser_done,
        input  grant, ack, err, err_id, ser_data, ser_start, busy
    );
endinterface

// File: rtl/pts_rr_arbiter.sv
// Round-robin sequencer that shares one parallel-to-serial shifter among NREQ requesters.
// A watchdog aborts any transfer whose shifter never reports done.
module pts_rr_arbiter #(
    parameter int WORD    = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             reset,
    pts_rr_arbiter_if.slave  bus
);
    localparam int IDXW = $clog2(NREQ);
    localparam int WDW  = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE,
        ABORT
    } state_t;

    state_t            state_q;
    logic [NREQ-1:0]   grant_q;
    logic [NREQ-1:0]   ack_q;
    logic              err_q;
    logic [2:0]        err_id_q;
    logic [WORD-1:0]   ser_data_q;
    logic              ser_start_q;
    logic              busy_q;
    logic [IDXW-1:0]   ptr_q;
    logic [IDXW-1:0]   owner_q;
    logic [WDW-1:0]    wdog_q;

    logic              win_vld_d;
    logic [IDXW-1:0]   win_idx_d;
    logic [IDXW-1:0]   cand;
    int                idx;

    // Search upward from ptr+1. The loop runs farthest-first so the nearest pending requester overwrites and wins.
    always_comb begin
        win_vld_d = 1'b0;
        win_idx_d = '0;
        cand      = '0;
        idx       = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx  = (int'(ptr_q) + k) % NREQ;
            cand = IDXW'(idx);
            if (bus.req[cand]) begin
                win_vld_d = 1'b1;
                win_idx_d = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ack_q       <= '0;
            err_q       <= 1'b0;
            err_id_q    <= '0;
            ser_data_q  <= '0;
            ser_start_q <= 1'b0;
            busy_q      <= 1'b0;
            ptr_q       <= IDXW'(NREQ - 1);
            owner_q     <= '0;
            wdog_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ser_start_q <= 1'b0;
                    ack_q       <= '0;
                    err_q       <= 1'b0;
                    if (win_vld_d) begin
                        grant_q    <= NREQ'(1) << win_idx_d;
                        owner_q    <= win_idx_d;
                        ser_data_q <= bus.data_in[int'(win_idx_d)*WORD +: WORD];
                        busy_q     <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    ser_start_q <= 1'b1;
                    wdog_q      <= '0;
                    state_q     <= SHIFT;
                end
                // A done seen on the last watchdog cycle still counts as success.
                SHIFT: begin
                    if (bus.ser_done) begin
                        ack_q       <= NREQ'(1) << owner_q;
                        ser_start_q <= 1'b0;
                        state_q     <= DONE;
                    end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                        err_q       <= 1'b1;
                        err_id_q    <= 3'(owner_q);
                        ser_start_q <= 1'b0;
                        state_q     <= ABORT;
                    end else begin
                        wdog_q      <= wdog_q + WDW'(1);
                    end
                end
                DONE, ABORT: begin
                    ptr_q       <= owner_q;
                    grant_q     <= '0;
                    ack_q       <= '0;
                    err_q       <= 1'b0;
                    ser_start_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    grant_q     <= '0;
                    ack_q       <= '0;
                    err_q       <= 1'b0;
                    ser_start_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.err_id    = err_id_q;
    assign bus.ser_data  = ser_data_q;
    assign bus.ser_start = ser_start_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_pts_rr_arbiter.sv
// Directed bench for pts_rr_arbiter: a shifter stub with a programmable done delay, plus hand-timed transfers.
// Every output is sampled on the falling edge.
module tb_pts_rr_arbiter;
    localparam int WORD    = 8;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pts_rr_arbiter_if #(.WORD(WORD), .NREQ(NREQ)) bus ();

    pts_rr_arbiter #(.WORD(WORD), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         vecCount  = 0;
    int         missCount = 0;
    int         doneAfter = 0;
    int         stubCnt   = 0;
    logic [2:0] lastErrId = 3'd0;
    logic [7:0] dataWord [NREQ];

    // Shifter stub: done rises doneAfter cycles after ser_start rises (never if 0) and clears when ser_start falls.
    initial begin
        bus.ser_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!bus.ser_start) begin
                stubCnt      = 0;
                bus.ser_done = 1'b0;
            end else begin
                stubCnt      = stubCnt + 1;
                bus.ser_done = (doneAfter > 0) && (stubCnt > doneAfter);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".grant"},    32'(bus.grant),     32'd0);
        checkOutput({tag, ".ack"},      32'(bus.ack),       32'd0);
        checkOutput({tag, ".err"},      32'(bus.err),       32'd0);
        checkOutput({tag, ".errId"},    32'(bus.err_id),    32'(lastErrId));
        checkOutput({tag, ".serStart"}, 32'(bus.ser_start), 32'd0);
        checkOutput({tag, ".busy"},     32'(bus.busy),      32'd0);
    endtask

    // Called on a falling edge with the DUT idle and req already driven; the grant happens on the next rising edge.
    task automatic applyStimulus(input int owner, input int doneCfg, input bit dropEarly, input bit dropOnEnd);
        logic [3:0] oh;
        oh        = 4'b0001 << owner;
        doneAfter = doneCfg;
        @(negedge clk);
        checkOutput("grant",      32'(bus.grant),     32'(oh));
        checkOutput("loadData",   32'(bus.ser_data),  32'(dataWord[owner]));
        checkOutput("loadStart",  32'(bus.ser_start), 32'd0);
        checkOutput("busyLoad",   32'(bus.busy),      32'd1);
        @(negedge clk);
        checkOutput("shiftStart", 32'(bus.ser_start), 32'd1);
        checkOutput("grantHold",  32'(bus.grant),     32'(oh));
        if (dropEarly) bus.req[owner] = 1'b0;
        if (doneCfg > 0) begin
            repeat (doneCfg) @(negedge clk);
            checkOutput("preAck",     32'(bus.ack),       32'd0);
            checkOutput("preErr",     32'(bus.err),       32'd0);
            @(negedge clk);
            checkOutput("ack",        32'(bus.ack),       32'(oh));
            checkOutput("noErr",      32'(bus.err),       32'd0);
            checkOutput("ackStart",   32'(bus.ser_start), 32'd0);
            checkOutput("dataStable", 32'(bus.ser_data),  32'(dataWord[owner]));
        end else begin
            repeat (TIMEOUT - 1) @(negedge clk);
            checkOutput("preTimeout", 32'(bus.err),       32'd0);
            @(negedge clk);
            checkOutput("err",        32'(bus.err),       32'd1);
            checkOutput("errId",      32'(bus.err_id),    32'(owner));
            checkOutput("noAck",      32'(bus.ack),       32'd0);
            checkOutput("abortStart", 32'(bus.ser_start), 32'd0);
            lastErrId = 3'(owner);
        end
        if (dropOnEnd) bus.req[owner] = 1'b0;
        @(negedge clk);
        checkIdle("idleAfter");
    endtask

    initial begin
        reset        = 1'b0;
        bus.req      = '0;
        dataWord[0]  = 8'hA5;
        dataWord[1]  = 8'h3C;
        dataWord[2]  = 8'h5A;
        dataWord[3]  = 8'hC3;
        for (int i = 0; i < NREQ; i++) bus.data_in[i*WORD +: WORD] = dataWord[i];

        #2;
        checkIdle("reset");
        checkOutput("resetData", 32'(bus.ser_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] single transfer on requester 0");
        bus.req = 4'b0001;
        applyStimulus(0, 9, 1'b0, 1'b1);

        $display("[TB] timeout on requester 2, then requester 0 served");
        bus.req = 4'b0101;
        applyStimulus(2, 0, 1'b0, 1'b1);
        applyStimulus(0, 5, 1'b0, 1'b1);

        $display("[TB] done on the final watchdog cycle");
        bus.req = 4'b0010;
        applyStimulus(1, TIMEOUT - 1, 1'b0, 1'b1);

        $display("[TB] req dropped during shift");
        bus.req = 4'b1000;
        applyStimulus(3, 6, 1'b1, 1'b1);

        $display("[TB] rotation after requester 3 served last");
        bus.req = 4'b1010;
        applyStimulus(1, 4, 1'b0, 1'b1);
        applyStimulus(3, 4, 1'b0, 1'b1);

        $display("[TB] reset in the middle of a shift");
        bus.req   = 4'b0010;
        doneAfter = 0;
        @(negedge clk);
        checkOutput("rstGrant", 32'(bus.grant), 32'b0010);
        @(negedge clk);
        checkOutput("rstShift", 32'(bus.ser_start), 32'd1);
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        lastErrId = 3'd0;
        checkIdle("midReset");
        checkOutput("midResetData", 32'(bus.ser_data), 32'd0);
        bus.req = 4'b1111;
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] round robin with all requesters held");
        applyStimulus(0, 3, 1'b0, 1'b0);
        applyStimulus(1, 2, 1'b0, 1'b0);
        applyStimulus(2, 7, 1'b0, 1'b0);
        applyStimulus(3, 1, 1'b0, 1'b0);
        applyStimulus(0, 3, 1'b0, 1'b0);
        bus.req = '0;
        @(negedge clk);
        checkIdle("final");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL simTimeout: observed running expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
